// File: rtl/game_pkg.sv
// Shared constants and types for the move entry path and the game FSM.
// Combinational definitions only; no latency.
// No flow control lives here; consumers apply their own handshakes.
package game_pkg;

  localparam int unsigned BOARD_SIZE = 10;
  localparam int unsigned COORD_W    = 4;
  localparam int unsigned ENTRY_W    = 2 * COORD_W;

  // Coordinate limit at coordinate width, so compares stay width-matched.
  localparam logic [COORD_W-1:0] BOARD_LIMIT = COORD_W'(BOARD_SIZE);
  // bit_count value meaning the entry buffer is full.
  localparam logic [3:0]         ENTRY_FULL  = 4'(ENTRY_W);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } entry_state_e;

  // x occupies the upper half, so the first bit entered lands in x's MSB.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } move_t;

  // Board-edge check only; occupancy is the game FSM's business.
  function automatic logic move_in_range(input move_t m);
    return (m.x < BOARD_LIMIT) && (m.y < BOARD_LIMIT);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to single press pulse: 2-FF sync, debounce, rising-edge detect.
// Latency: press_pulse rises 2 + DEBOUNCE_CYCLES clocks after the raw level change.
// No backpressure: the pulse is one cycle wide and is lost if not sampled.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Count consecutive samples that disagree with the accepted level; flip after a full run.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      pulse_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, debounce state and pulse register, all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/move_entry_collector.sv
// Collects button-entered bits into a range-checked (x,y) move for the game FSM.
// Latency: buffer/state update 1 clock after a conditioned press pulse (3 + DEBOUNCE_CYCLES from the raw press).
// Backpressure: a move is held on move_valid until move_ready; buttons are ignored meanwhile.
module move_entry_collector
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               logic_0_button,
  input  logic               logic_1_button,
  input  logic               activity_button,
  input  logic               accept_en,
  input  logic               move_ready,
  output logic               move_valid,
  output logic [COORD_W-1:0] move_x,
  output logic [COORD_W-1:0] move_y,
  output logic               entry_error,
  output logic [ENTRY_W-1:0] entry_bits,
  output logic [3:0]         bit_count
);

  logic bit0_pulse;
  logic bit1_pulse;
  logic act_pulse;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_bit0 (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (logic_0_button),
    .press_pulse (bit0_pulse)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_bit1 (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (logic_1_button),
    .press_pulse (bit1_pulse)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_act (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (activity_button),
    .press_pulse (act_pulse)
  );

  entry_state_e state_q, state_d;
  move_t        entry_q, entry_d;
  logic [3:0]   count_q, count_d;
  move_t        move_q,  move_d;
  logic         error_q, error_d;

  // Entry FSM: shift bits while collecting, validate on submit, hold the move until consumed.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    move_d  = move_q;
    error_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept_en) begin
          // Submit takes priority over any bit pressed in the same cycle.
          if (act_pulse) begin
            if ((count_q == ENTRY_FULL) && move_in_range(entry_q)) begin
              move_d  = entry_q;
              state_d = PRESENT;
            end else begin
              error_d = 1'b1;
              entry_d = '0;
              count_d = '0;
            end
          // Both bit buttons at once is ambiguous, so neither is taken; a full buffer never wraps.
          end else if ((bit0_pulse ^ bit1_pulse) && (count_q < ENTRY_FULL)) begin
            entry_d = move_t'({entry_q[ENTRY_W-2:0], bit1_pulse});
            count_d = count_q + 4'd1;
          end
        end
      end
      PRESENT: begin
        if (move_ready) begin
          state_d = COLLECT;
          entry_d = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Entry state registers; reset discards any partial entry and pending move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      entry_q <= '0;
      count_q <= '0;
      move_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      move_q  <= move_d;
      error_q <= error_d;
    end
  end

  assign move_valid  = (state_q == PRESENT);
  assign move_x      = move_q.x;
  assign move_y      = move_q.y;
  assign entry_error = error_q;
  assign entry_bits  = entry_q;
  assign bit_count   = count_q;

endmodule
